// File: rtl/io_controller_if.sv
// CPU, switch, key and display signals of io_controller.
// master: CPU/board side; slave: the controller.
interface io_controller_if;
  logic        in_req;
  logic        out_req;
  logic [31:0] cpu_data;
  logic [15:0] switches;
  logic        key_n;
  logic        stall;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] disp_value;
  logic        in_on;
  logic        out_on;

  modport master (
    output in_req,
    output out_req,
    output cpu_data,
    output switches,
    output key_n,
    input  stall,
    input  in_data,
    input  in_valid,
    input  disp_value,
    input  in_on,
    input  out_on
  );

  modport slave (
    input  in_req,
    input  out_req,
    input  cpu_data,
    input  switches,
    input  key_n,
    output stall,
    output in_data,
    output in_valid,
    output disp_value,
    output in_on,
    output out_on
  );
endinterface

// File: rtl/io_controller.sv
// Stalls the CPU on IN/OUT, drives the display path and
// waits for a debounced key press and release.
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic            clock,
  input logic            reset,
  io_controller_if.slave io
);

  typedef enum logic [2:0] {
    IDLE,
    IN_WAIT,
    IN_REL,
    OUT_WAIT,
    OUT_REL,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic        key_s1;
  logic        key_s2;
  logic        key_db;
  logic        key_db_q;
  logic [CNT_W-1:0] cnt;
  logic        key_press;
  logic        key_release;
  logic [31:0] sw_ext;
  logic [31:0] disp_q;
  logic [31:0] disp_n;
  logic [31:0] in_data_q;
  logic [31:0] in_data_n;
  logic        in_valid_q;
  logic        in_valid_n;
  logic        in_on_q;
  logic        in_on_n;
  logic        out_on_q;
  logic        out_on_n;

  // key path: synchronizer, then a level must hold for
  // the full window before key_db follows it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_db   <= 1'b1;
      key_db_q <= 1'b1;
      cnt      <= '0;
    end else begin
      key_s1   <= io.key_n;
      key_s2   <= key_s1;
      key_db_q <= key_db;
      if (key_s2 == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        key_db <= key_s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign key_press   = key_db_q & ~key_db;
  assign key_release = ~key_db_q & key_db;
  assign sw_ext      = {{16{io.switches[15]}}, io.switches};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      disp_q     <= '0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      in_on_q    <= 1'b0;
      out_on_q   <= 1'b0;
    end else begin
      state      <= state_n;
      disp_q     <= disp_n;
      in_data_q  <= in_data_n;
      in_valid_q <= in_valid_n;
      in_on_q    <= in_on_n;
      out_on_q   <= out_on_n;
    end
  end

  always_comb begin
    state_n    = state;
    disp_n     = disp_q;
    in_data_n  = in_data_q;
    in_valid_n = 1'b0;
    in_on_n    = in_on_q;
    out_on_n   = out_on_q;
    unique case (state)
      IDLE: begin
        if (io.in_req) begin
          state_n  = IN_WAIT;
          in_on_n  = 1'b1;
          out_on_n = 1'b0;
          disp_n   = sw_ext;
        end else if (io.out_req) begin
          state_n  = OUT_WAIT;
          in_on_n  = 1'b0;
          out_on_n = 1'b1;
          disp_n   = io.cpu_data;
        end
      end
      IN_WAIT: begin
        disp_n = sw_ext;
        if (key_press) begin
          in_data_n = sw_ext;
          state_n   = IN_REL;
        end
      end
      IN_REL: begin
        if (key_release) begin
          in_valid_n = 1'b1;
          in_on_n    = 1'b0;
          state_n    = DONE;
        end
      end
      OUT_WAIT: begin
        if (key_press) state_n = OUT_REL;
      end
      OUT_REL: begin
        if (key_release) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // stall rises combinationally with the request
  assign io.stall =
    ((state == IDLE) & (io.in_req | io.out_req)) |
    (state == IN_WAIT) | (state == IN_REL) |
    (state == OUT_WAIT) | (state == OUT_REL);

  assign io.disp_value = disp_q;
  assign io.in_data    = in_data_q;
  assign io.in_valid   = in_valid_q;
  assign io.in_on      = in_on_q;
  assign io.out_on     = out_on_q;

endmodule
